// File: rtl/multi_fifo_arbiter.sv
// multi_fifo_arbiter: merges N_CH source word FIFOs into one FIFO-style read
// port for out_fifo. The arbiter uses round-robin fairness, an optional
// priority channel, bounded bursts and per-channel enables. The merged
// read/empty/data path is combinational from the registered grant, so a
// granted word is presented with no extra pipeline stage.
module multi_fifo_arbiter #(
  parameter int N_CH      = 4,
  parameter int DSIZE     = 32,
  parameter int PRIO_CH   = N_CH - 1,
  parameter int MAX_BURST = 1,
  localparam int ID_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST,
  input  logic [N_CH-1:0]       CH_ENABLE,
  input  logic [N_CH-1:0]       CH_EMPTY,
  input  logic [N_CH*DSIZE-1:0] CH_DATA,
  output logic [N_CH-1:0]       CH_READ,
  input  logic                  FIFO_READ,
  output logic                  FIFO_EMPTY,
  output logic [DSIZE-1:0]      FIFO_DATA,
  output logic                  GRANT_VALID,
  output logic [ID_W-1:0]       GRANT_ID
);

  // An out-of-range PRIO_CH turns the priority override off entirely.
  localparam logic            PRIO_ON    = (PRIO_CH >= 0) && (PRIO_CH < N_CH);
  localparam int              PRIO_IDX   = PRIO_ON ? PRIO_CH : 0;
  localparam logic [ID_W-1:0] PRIO_ID    = ID_W'(PRIO_IDX);
  localparam logic [ID_W-1:0] LAST_ID    = ID_W'(N_CH - 1);
  localparam logic [7:0]      BURST_LAST = 8'(MAX_BURST - 1);

  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic [7:0]      burst_cnt;

  logic            next_valid;
  logic [ID_W-1:0] next_id;
  logic [7:0]      next_cnt;

  logic [N_CH-1:0] eligible;
  logic            leave_burst;
  logic            rearb;
  logic            prio_take;
  logic            rr_found;
  logic [ID_W-1:0] rr_id;
  int              rr_idx;

  // Decide whether to re-arbitrate this cycle and which channel wins.
  always_comb begin
    eligible    = CH_ENABLE & ~CH_EMPTY;
    leave_burst = grant_valid & FIFO_READ & (burst_cnt == BURST_LAST);
    rearb       = ~grant_valid | leave_burst |
                  (~FIFO_READ & (CH_EMPTY[grant_id] | ~CH_ENABLE[grant_id]));

    // The priority channel may not immediately re-take a grant it just
    // finished a full burst on, so other channels cannot be starved.
    prio_take   = PRIO_ON && eligible[PRIO_IDX] &&
                  !(leave_burst && (grant_id == PRIO_ID));

    // Round-robin starts just after the current grant and wraps at N_CH,
    // so the current channel is the last candidate examined.
    rr_found = 1'b0;
    rr_id    = grant_id;
    rr_idx   = 0;
    for (int k = 1; k <= N_CH; k++) begin
      rr_idx = int'(grant_id) + k;
      if (rr_idx >= N_CH) rr_idx = rr_idx - N_CH;
      if (!rr_found && eligible[ID_W'(rr_idx)]) begin
        rr_found = 1'b1;
        rr_id    = ID_W'(rr_idx);
      end
    end

    next_valid = grant_valid;
    next_id    = grant_id;
    next_cnt   = burst_cnt;
    if (rearb) begin
      next_cnt = 8'd0;
      if (prio_take) begin
        next_valid = 1'b1;
        next_id    = PRIO_ID;
      end else if (rr_found) begin
        next_valid = 1'b1;
        next_id    = rr_id;
      end else begin
        next_valid = 1'b0;
      end
    end else if (FIFO_READ) begin
      next_cnt = burst_cnt + 8'd1;
    end
  end

  // Grant state register; reset parks the pointer so the first search hits channel 0.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      grant_valid <= 1'b0;
      grant_id    <= LAST_ID;
      burst_cnt   <= 8'd0;
    end else begin
      grant_valid <= next_valid;
      grant_id    <= next_id;
      burst_cnt   <= next_cnt;
    end
  end

  // Steer the merged read port onto the granted channel.
  always_comb begin
    CH_READ = '0;
    for (int i = 0; i < N_CH; i++) begin
      CH_READ[i] = grant_valid & (grant_id == ID_W'(i)) & FIFO_READ;
    end
    FIFO_EMPTY  = ~grant_valid | CH_EMPTY[grant_id];
    FIFO_DATA   = grant_valid ? CH_DATA[int'(grant_id)*DSIZE +: DSIZE] : '0;
    GRANT_VALID = grant_valid;
    GRANT_ID    = grant_id;
  end

endmodule
